// File: rtl/wrapper_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wrapper_test_sequencer
// Description : Command-driven sequencer for the IEEE 1500 wrapper around the
//               example RAM core. It runs load/update/capture/unload on the
//               serial WBR path, or an MBIST pass with a timeout.
//               Optional macro SEQ_COMPARE_EN adds the expected/mismatch compare.
// Revision    : 1.0 - initial release
// ============================================================================
module wrapper_test_sequencer #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int MBIST_TO  = 64
) (
  input  logic                 WRCK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [1:0]           instr,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 wbr_so,
  input  logic                 mbist_done,
  input  logic                 mbist_fail,
`ifdef SEQ_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 mismatch,
`endif
  output logic                 wbr_si,
  output logic                 wse_inputs,
  output logic                 wse_outputs,
  output logic                 se,
  output logic                 hold_inputs,
  output logic                 hold_outputs,
  output logic                 wbr_update,
  output logic                 scanmode,
  output logic                 mbistmode,
  output logic                 wir_extest,
  output logic                 wpp_bypass,
  output logic                 bus_disable,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 timeout
);

  // One counter serves both the shift phases and the MBIST timeout.
  localparam int TO_W = $clog2(MBIST_TO + 1);
  localparam int CW   = (CNT_W > TO_W) ? CNT_W : TO_W;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(MBIST_TO - 1);

  localparam logic [1:0] INSTR_BYPASS = 2'b00;
  localparam logic [1:0] INSTR_EXTEST = 2'b01;
  localparam logic [1:0] INSTR_INTEST = 2'b10;
  localparam logic [1:0] INSTR_MBIST  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_LOAD      = 3'd2,
    S_UPDATE    = 3'd3,
    S_CAPTURE   = 3'd4,
    S_UNLOAD    = 3'd5,
    S_MBIST_RUN = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           instr_q, instr_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] result_q, result_d;
  logic                 timeout_q, timeout_d;
`ifdef SEQ_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_q, expected_d;
  logic                 mismatch_q, mismatch_d;
`endif

  always_ff @(posedge WRCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      pat_q      <= '0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
`ifdef SEQ_COMPARE_EN
      expected_q <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      pat_q      <= pat_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
`ifdef SEQ_COMPARE_EN
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    pat_d      = pat_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
`ifdef SEQ_COMPARE_EN
    expected_d = expected_q;
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          instr_d    = instr;
          pat_d      = pattern;
          timeout_d  = 1'b0;
`ifdef SEQ_COMPARE_EN
          expected_d = expected;
          mismatch_d = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = (instr_q == INSTR_MBIST) ? S_MBIST_RUN : S_LOAD;
      end
      S_LOAD: begin
        pat_d    = pat_q >> 1;
        result_d = {wbr_so, result_q[CHAIN_LEN-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == SHIFT_LAST) begin
          state_d = (instr_q == INSTR_BYPASS) ? S_DONE : S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        result_d = {wbr_so, result_q[CHAIN_LEN-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_MBIST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // A completion on the final count beats the timeout.
        if (mbist_done) begin
          result_d    = '0;
          result_d[0] = mbist_fail;
          state_d     = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          result_d    = '0;
          result_d[1] = 1'b1;
          timeout_d   = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
`ifdef SEQ_COMPARE_EN
        mismatch_d = (instr_q == INSTR_MBIST) ? result_q[0] : (result_q != expected_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic shift_w;
  assign shift_w      = (state_q == S_LOAD) || (state_q == S_UNLOAD);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign se           = shift_w;
  assign wse_inputs   = shift_w;
  assign wse_outputs  = shift_w;
  assign wbr_si       = (state_q == S_LOAD) & pat_q[0];
  assign hold_inputs  = busy && (state_q != S_CAPTURE);
  assign hold_outputs = busy && (state_q != S_CAPTURE);
  assign wbr_update   = (state_q == S_UPDATE);
  assign wir_extest   = busy && (instr_q == INSTR_EXTEST);
  assign bus_disable  = busy && (instr_q == INSTR_EXTEST);
  assign scanmode     = busy && (instr_q == INSTR_INTEST);
  assign wpp_bypass   = busy && (instr_q == INSTR_BYPASS);
  assign mbistmode    = busy && (instr_q == INSTR_MBIST);
  assign result       = result_q;
  assign timeout      = timeout_q;
`ifdef SEQ_COMPARE_EN
  assign mismatch     = mismatch_q;
`endif

endmodule
`default_nettype wire
